// File: rtl/thirty_two_bit_lookahead_adder.sv
// Registered 32-bit two-level carry-lookahead adder.
// Eight 4-bit lookahead blocks feed a second-level carry unit. The unit
// computes every block carry-in directly from cin and the group (G, P)
// pairs, so no carry ripples across a 4-bit block boundary.
// S and cout come straight from flops.

// 4-bit lookahead block: internal carries plus group generate/propagate.
module cla_block4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c_in,
  output logic [3:0] c,
  output logic       group_g,
  output logic       group_p
);

  // Flattened in-block carries: each one is a single sum of products.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
  end

  // Group terms depend only on g/p, never on c_in. This keeps them off
  // the carry path into the second-level unit.
  always_comb begin
    group_p = p[3] & p[2] & p[1] & p[0];
    group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// Second-level lookahead unit: block carry-ins from cin and group (G, P).
module cla_carry_unit (
  input  logic [7:0] grp_g,
  input  logic [7:0] grp_p,
  input  logic       c_in,
  output logic [7:0] blk_c
);

  logic acc;
  logic term;

  // Each block carry is expanded as
  //   OR_j ( G[j] & P[j+1..k-1] ) | ( cin & P[0..k-1] ).
  // The loops build a flat sum of products, not a ripple chain.
  always_comb begin
    acc   = 1'b0;
    term  = 1'b0;
    blk_c = '0;
    blk_c[0] = c_in;
    for (int k = 1; k < 8; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      term = c_in;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      blk_c[k] = acc | term;
    end
  end

endmodule

// Top level: bit g/p, eight lookahead blocks, carry unit, output register.
module thirty_two_bit_lookahead_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cin,
  output logic [31:0] S,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c_bit;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [7:0]  blk_c;
  logic [31:0] s_next;
  logic        cout_next;

  // Per-bit generate and propagate.
  always_comb begin
    g = A & B;
    p = A ^ B;
  end

  cla_carry_unit u_carry (
    .grp_g (grp_g),
    .grp_p (grp_p),
    .c_in  (cin),
    .blk_c (blk_c)
  );

  for (genvar b = 0; b < 8; b++) begin : gen_blk
    cla_block4 u_blk (
      .g       (g[4*b +: 4]),
      .p       (p[4*b +: 4]),
      .c_in    (blk_c[b]),
      .c       (c_bit[4*b +: 4]),
      .group_g (grp_g[b]),
      .group_p (grp_p[b])
    );
  end

  // Sum bits and the carry out of bit 31, taken from block 7's group
  // terms and its carry-in.
  always_comb begin
    s_next    = p ^ c_bit;
    cout_next = grp_g[7] | (grp_p[7] & blk_c[7]);
  end

  // Output register. Reset clears it asynchronously, which drops any
  // result still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      cout <= 1'b0;
    end else begin
      S    <= s_next;
      cout <= cout_next;
    end
  end

endmodule

// File: tb/tb_thirty_two_bit_lookahead_adder.sv
// Scoreboard bench for the registered 32-bit lookahead adder.
// Stimulus drives operands on falling edges and queues the expected
// {cout, S}. The monitor pops one entry and compares it after each
// rising edge.
`timescale 1ns/1ps
module tb_thirty_two_bit_lookahead_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic [31:0] S;
  logic        cout;

  int checks;
  int errors;

  logic [32:0] exp_q[$];
  logic [32:0] last_exp;
  logic        last_valid;

  thirty_two_bit_lookahead_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got cout=%0b S=%08h want cout=%0b S=%08h at %0t",
               name, got[32], got[31:0], want[32], want[31:0], $time);
    end
  endtask

  // Drive one operand set. Its expected result is queued, and the
  // previous result is confirmed to hold while the inputs change.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [32:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    cin = c;
    exp_q.push_back(exp);
    #1;
    if (last_valid) check("hold", {cout, S}, last_exp);
  endtask

  // Monitor: compare each registered result against the scoreboard.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", {cout, S}, e);
        last_exp   = e;
        last_valid = 1'b1;
      end
    end
  end

  // Assert reset at a random point inside the high phase and check the
  // outputs clear without a clock. Reset is then held across an edge.
  task automatic mid_reset();
    @(posedge clk);
    #($urandom_range(2, 3));
    rst_n = 1'b0;
    #1;
    check("async_reset", {cout, S}, 33'h0);
    last_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_hold", {cout, S}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    int          waited;
    checks     = 0;
    errors     = 0;
    last_valid = 1'b0;
    last_exp   = '0;
    rst_n      = 1'b1;
    A          = 32'hFFFF_FFFF;
    B          = 32'hFFFF_FFFF;
    cin        = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async_start", {cout, S}, 33'h0);
    repeat (3) begin
      @(negedge clk);
      check("reset_clocked", {cout, S}, 33'h0);
    end

    // Release reset. The first rising edge captures FFFFFFFF + FFFFFFFF + 1.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});

    issue(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0000_0000});
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 32'h0000_0000});
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, {1'b0, 32'hFFFF_FFFF});
    issue(32'h0000_000F, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_0010});
    issue(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h1000_0000});
    issue(32'h0000_0001, 32'h0000_0002, 1'b0, {1'b0, 32'h0000_0003});
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h8000_0000});
    issue(32'h1234_5678, 32'h8765_4321, 1'b1, {1'b0, 32'h9999_999A});
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h0001_0000});
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {1'b1, 32'hFFFF_FFFE});
    issue(32'h0000_0000, 32'h0000_0000, 1'b1, {1'b0, 32'h0000_0001});
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, {1'b1, 32'h0000_0000});
    issue(32'h89AB_CDEF, 32'h7654_3210, 1'b0, {1'b0, 32'hFFFF_FFFF});
    issue(32'h0000_0000, 32'h0000_0000, 1'b0, {1'b0, 32'h0000_0000});

    for (int i = 0; i < 10000; i++) begin
      if (i == 2500 || i == 5000 || i == 7500) mid_reset();
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'h0, rc});
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending results want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/thirty_two_bit_lookahead_adder.md
# thirty_two_bit_lookahead_adder

Registered 32-bit carry-lookahead adder: computes A + B + cin and presents the 32-bit sum and carry-out one clock after the operands are sampled. The adder is the integer add path of the processor datapath, and its carry chain is built from hierarchical generate/propagate logic rather than ripple carry. Operands are free-running, so a new addition may be issued every cycle.

## Interface
Parameters:
- None. The width is fixed at 32 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- A  input  32  first operand, unsigned or two's complement.
- B  input  32  second operand.
- cin  input  1  carry-in.
- S  output  32  registered sum, A + B + cin mod 2^32.
- cout  output  1  registered carry-out of bit 31.

## Operation
Carry structure:
- Per bit i: g[i] = A[i] & B[i] and p[i] = A[i] ^ B[i].
- Carries are built from eight 4-bit lookahead blocks. Each block computes its internal carries from g/p and its block carry-in.
- Each block also produces a group generate G and a group propagate P.
  - P = p3 & p2 & p1 & p0.
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- A second-level lookahead unit uses the eight (G, P) pairs and cin to compute the eight block carry-ins. Block 0's carry-in is cin.
- The top-level carry-out is derived from block 7's (G, P) and its carry-in.
- No ripple carry may cross a 4-bit block boundary.

Outputs:
- Sum bit: s[i] = p[i] ^ c[i], where c[0] = cin.
- cout_next = c[32] = G7 | P7 & c[28].
- No overflow flag. Signed overflow is not reported.

Arithmetic rules:
- The result is exact modulo 2^32.
- cout is the unsigned carry.
- The all-propagate case (A ^ B = all ones) must pass cin through to cout. For example, 0xFFFFFFFF + 0x00000000 + 1 gives S = 0 and cout = 1.

Reset:
- While rst_n = 0, S = 0x00000000 and cout = 0, regardless of clk or the inputs.

## Timing
- Inputs A, B and cin are sampled on the rising edge of clk. S and cout update on that same edge with the combinational result of the sampled inputs. Latency is 1 cycle and throughput is 1 result per cycle.
- S and cout are driven directly from flops, with no combinational path from the inputs to the outputs.
- Reset assertion is asynchronous: S and cout clear immediately, with no clock needed.
  - If reset is asserted mid-operation, the pending result is discarded.
- Reset deassertion takes effect at the next rising edge. The first valid result appears at the first rising clk edge with rst_n = 1 and reflects the inputs present at that edge.
- Inputs that change between edges have no effect on the outputs until the next edge.
- Back-to-back operands on consecutive edges produce back-to-back results with no bubbles.
- The critical path (g/p, then group G/P, then the second-level carry, then the block carry, then the sum XOR) must close timing at the datapath clock.

## Test plan
- **Reset.** Hold rst_n = 0 with A = B = 0xFFFFFFFF and cin = 1, and toggle clk. Required: S = 0 and cout = 0. Then release rst_n. Required: the next edge gives S = 0xFFFFFFFF and cout = 1.
- **MSB carry-out.** A = 0x80000000, B = 0x80000000, cin = 0. Required: one cycle later, S = 0x00000000 and cout = 1.
- **Full propagate chain.** A = 0xFFFFFFFF, B = 0x00000000, cin = 1. Required: S = 0x00000000 and cout = 1. Repeat with cin = 0. Required: S = 0xFFFFFFFF and cout = 0.
- **Block-boundary carries.** A = 0x0000000F, B = 0x00000001, cin = 0 gives S = 0x00000010 and cout = 0. A = 0x0FFFFFFF, B = 0x00000001 gives S = 0x10000000 and cout = 0.
- **Pipelined stream.** On consecutive edges apply (1, 2, 0), then (0x7FFFFFFF, 1, 0), then (0x12345678, 0x87654321, 1). Required on successive edges:
  - S = 0x00000003, cout = 0.
  - S = 0x80000000, cout = 0.
  - S = 0x9999999A, cout = 0.
- **Random regression.** At least 10,000 random (A, B, cin) triples. Required: {cout, S} equals the 33-bit A + B + cin, checked one cycle after each is applied. Assert rst_n asynchronously at a random mid-cycle point. Required: the outputs are 0 immediately.
